// File: rtl/tl_pkg.sv
// Shared encodings and lamp decode for the tail-light sequencer.
// Lamp bits: LC LB LA on 5:3, RC RB RA on 2:0.
package tl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    STEP_OFF = 3'd0,
    STEP_S1  = 3'd1,
    STEP_S2  = 3'd2,
    STEP_S3  = 3'd3,
    STEP_ON  = 3'd4
  } step_t;

  localparam logic [5:0] PAT_L1   = 6'b001000;
  localparam logic [5:0] PAT_L2   = 6'b011000;
  localparam logic [5:0] PAT_L3   = 6'b111000;
  localparam logic [5:0] PAT_R1   = 6'b000001;
  localparam logic [5:0] PAT_R2   = 6'b000011;
  localparam logic [5:0] PAT_R3   = 6'b000111;
  localparam logic [5:0] PAT_ALL  = 6'b111111;
  localparam logic [5:0] PAT_NONE = 6'b000000;

  function automatic step_t next_step(input mode_t m, input step_t s);
    step_t n;
    n = STEP_OFF;
    if (m == MODE_HAZ) begin
      n = (s == STEP_ON) ? STEP_OFF : STEP_ON;
    end else begin
      case (s)
        STEP_S1: n = STEP_S2;
        STEP_S2: n = STEP_S3;
        STEP_S3: n = STEP_OFF;
        default: n = STEP_S1;
      endcase
    end
    return n;
  endfunction

  // Brake fills the side that is not sweeping; hazard ignores brake.
  function automatic logic [5:0] lamp_decode(input mode_t m, input step_t s, input logic brake);
    logic [5:0] p;
    p = PAT_NONE;
    case (m)
      MODE_LEFT: begin
        case (s)
          STEP_S1: p = PAT_L1;
          STEP_S2: p = PAT_L2;
          STEP_S3: p = PAT_L3;
          default: p = PAT_NONE;
        endcase
        if (brake) p = p | PAT_R3;
      end
      MODE_RIGHT: begin
        case (s)
          STEP_S1: p = PAT_R1;
          STEP_S2: p = PAT_R2;
          STEP_S3: p = PAT_R3;
          default: p = PAT_NONE;
        endcase
        if (brake) p = p | PAT_L3;
      end
      MODE_HAZ: p = (s == STEP_ON) ? PAT_ALL : PAT_NONE;
      default:  p = brake ? PAT_ALL : PAT_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer followed by a stability filter: the clean value
// follows the synchronized input only after DEB_LEN consecutive differing samples.
module tl_debounce #(
  parameter int DEB_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEB_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] remain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      clean  <= 1'b0;
      remain <= RELOAD;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any agreement with the current clean value restarts the count.
      if (sync2 == clean) begin
        remain <= RELOAD;
      end else if (remain == '0) begin
        clean  <= sync2;
        remain <= RELOAD;
      end else begin
        remain <= remain - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Turn-signal controller: debounces the driver switches, arbitrates a mode
// and sweeps the six tail lamps at a programmable step rate.
//
// mode  | meaning
// IDLE  | no turn request; lamps dark unless braking
// LEFT  | left sweep S1 -> S2 -> S3 -> OFF
// RIGHT | right sweep S1 -> S2 -> S3 -> OFF
// HAZ   | hazard (or both turns): all lamps ON <-> OFF
module tail_light_sequencer
  import tl_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int DEB_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       hazard_in,
  input  logic       brake_in,
  output logic [5:0] lamps,
  output logic [1:0] mode,
  output logic       step_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);

  logic left_deb, right_deb, hazard_deb, brake_deb;

  tl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_left   (.clk(clk), .reset(reset), .raw(left_in),   .clean(left_deb));
  tl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_right  (.clk(clk), .reset(reset), .raw(right_in),  .clean(right_deb));
  tl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_hazard (.clk(clk), .reset(reset), .raw(hazard_in), .clean(hazard_deb));
  tl_debounce #(.DEB_LEN(DEB_LEN)) u_deb_brake  (.clk(clk), .reset(reset), .raw(brake_in),  .clean(brake_deb));

  mode_t         mode_q;
  mode_t         arb;
  step_t         step_q;
  logic [PW-1:0] presc;

  always_comb begin
    arb = MODE_IDLE;
    if (hazard_deb || (left_deb && right_deb)) arb = MODE_HAZ;
    else if (left_deb)                         arb = MODE_LEFT;
    else if (right_deb)                        arb = MODE_RIGHT;
  end

  // step_tick is registered so it is high exactly while presc sits at TICK_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_IDLE;
      step_q    <= STEP_OFF;
      presc     <= '0;
      step_tick <= 1'b0;
      lamps     <= PAT_NONE;
    end else begin
      lamps <= lamp_decode(mode_q, step_q, brake_deb);
      if (arb != mode_q) begin
        mode_q    <= arb;
        presc     <= '0;
        step_tick <= 1'b0;
        case (arb)
          MODE_LEFT, MODE_RIGHT: step_q <= STEP_S1;
          MODE_HAZ:              step_q <= STEP_ON;
          default:               step_q <= STEP_OFF;
        endcase
      end else if (mode_q == MODE_IDLE) begin
        presc     <= '0;
        step_tick <= 1'b0;
        step_q    <= STEP_OFF;
      end else begin
        step_tick <= (presc == PRESC_PRE);
        if (presc == PRESC_LAST) begin
          presc  <= '0;
          step_q <= next_step(mode_q, step_q);
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with a phase-based reference model.
module tb_tail_light_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB_LEN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_in = 1'b0, right_in = 1'b0, hazard_in = 1'b0, brake_in = 1'b0;
  logic [5:0] lamps;
  logic [1:0] mode;
  logic       step_tick;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tail_light_sequencer #(.TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN)) dut (
    .clk(clk), .reset(reset),
    .left_in(left_in), .right_in(right_in), .hazard_in(hazard_in), .brake_in(brake_in),
    .lamps(lamps), .mode(mode), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model: mode is a function of debounced switches; step and prescaler are
  // derived from the number of cycles spent in the current mode (phase).
  logic [3:0]         m_s1, m_s2, m_deb;   // [0]=left [1]=right [2]=hazard [3]=brake
  logic [DEB_LEN-1:0] m_hist [4];
  logic [3:0]         m_raw;
  int                 m_mode, m_phase, m_arb;
  logic [5:0]         m_lamps;
  logic               exp_tick;

  function automatic logic [5:0] pattern(input int md, input int ph, input logic brk);
    int k, n, p;
    k = ph / TICK_DIV;
    n = (k % 4 == 3) ? 0 : (k % 4) + 1;   // lamps lit on the sweeping side
    p = 0;
    case (md)
      1: p = (((1 << n) - 1) << 3) | (brk ? 7 : 0);
      2: p = ((1 << n) - 1) | (brk ? 56 : 0);
      3: p = (k % 2 == 0) ? 63 : 0;
      default: p = brk ? 63 : 0;
    endcase
    return 6'(p);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
      m_mode = 0; m_phase = 0; m_lamps = '0;
    end else begin
      m_raw = {brake_in, hazard_in, right_in, left_in};
      m_lamps = pattern(m_mode, m_phase, m_deb[3]);
      m_arb = (m_deb[2] || (m_deb[0] && m_deb[1])) ? 3 : m_deb[0] ? 1 : m_deb[1] ? 2 : 0;
      if (m_arb != m_mode) begin
        m_mode = m_arb;
        m_phase = 0;
      end else if (m_mode != 0) m_phase++;
      else m_phase = 0;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = (m_hist[i] << 1) | DEB_LEN'(m_s2[i]);
        if (m_hist[i] == (m_deb[i] ? {DEB_LEN{1'b0}} : {DEB_LEN{1'b1}})) m_deb[i] = ~m_deb[i];
      end
      m_s2 = m_s1;
      m_s1 = m_raw;
    end
  end

  always @(negedge clk) begin
    exp_tick = (m_mode != 0) && (m_phase % TICK_DIV == TICK_DIV - 1);
    check("lamps", lamps, m_lamps);
    check("mode", 6'(mode), 6'(m_mode));
    check("step_tick", 6'(step_tick), 6'(exp_tick));
  end

  task automatic wait_mode(input logic [1:0] m, input int budget, input string name);
    int n;
    n = 0;
    while (mode !== m && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 6'(mode), 6'(m));
  endtask

  logic [5:0] sweep [4];

  initial begin
    sweep[0] = 6'b011000; sweep[1] = 6'b111000; sweep[2] = 6'b000000; sweep[3] = 6'b001000;
    #1 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      {brake_in, hazard_in, right_in, left_in} = 4'($urandom_range(0, 15));
    end
    check("rst_lamps", lamps, 6'b000000);
    check("rst_mode", 6'(mode), 6'd0);
    @(negedge clk);
    {brake_in, hazard_in, right_in, left_in} = 4'b0000;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_release", lamps, 6'b000000);

    // pulse one shorter than the filter, then one exactly as long
    left_in = 1'b1;
    repeat (DEB_LEN - 1) @(negedge clk);
    left_in = 1'b0;
    repeat (8) @(negedge clk);
    check("short_pulse_mode", 6'(mode), 6'd0);
    left_in = 1'b1;
    repeat (DEB_LEN) @(negedge clk);
    left_in = 1'b0;
    repeat (20) @(negedge clk);

    left_in = 1'b1;
    repeat (6) @(negedge clk);
    check("left_mode", 6'(mode), 6'd1);
    check("left_pre", lamps, 6'b000000);
    @(negedge clk);
    check("left_s1", lamps, 6'b001000);
    for (int k = 0; k < 4; k++) begin
      repeat (TICK_DIV) @(negedge clk);
      check("left_sweep", lamps, sweep[k]);
    end

    repeat (5) begin
      right_in = 1'b1;
      @(negedge clk);
      right_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("glitch_mode", 6'(mode), 6'd1);

    right_in = 1'b1;
    wait_mode(2'd3, 20, "haz_from_both");
    repeat (20) @(negedge clk);
    left_in = 1'b0;
    wait_mode(2'd2, 20, "right_after_drop");
    @(negedge clk);
    check("right_s1", lamps, 6'b000001);
    repeat (16) @(negedge clk);

    brake_in = 1'b1;
    repeat (30) @(negedge clk);
    right_in = 1'b0;
    wait_mode(2'd0, 20, "idle_with_brake");
    repeat (3) @(negedge clk);
    check("brake_idle", lamps, 6'b111111);

    hazard_in = 1'b1;
    wait_mode(2'd3, 20, "haz_with_brake");
    repeat (20) @(negedge clk);
    hazard_in = 1'b0;
    brake_in = 1'b0;
    wait_mode(2'd0, 20, "idle_again");
    repeat (6) @(negedge clk);

    left_in = 1'b1;
    begin
      int n;
      n = 0;
      while (lamps !== 6'b011000 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("reach_l2", lamps, 6'b011000);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_rst_lamps", lamps, 6'b000000);
    check("async_rst_mode", 6'(mode), 6'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("rel_pre", lamps, 6'b000000);
    @(negedge clk);
    check("rel_s1", lamps, 6'b001000);
    left_in = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
Top-level turn-signal controller for the 6-lamp tail-light datapath (left lamps LC LB LA = bits 5:3, right lamps RA RB RC = bits 0:2).
- Debounces raw driver switches (left, right, hazard, brake) and arbitrates them into one operating mode.
- Paces the sweep with a programmable prescaler and drives the registered 6-bit lamp pattern.
- Sits between the dashboard switch inputs and the lamp drivers.

Parameters:
- TICK_DIV, 4, clock cycles per sequence step (>=2).
- DEB_LEN, 3, consecutive stable synchronized samples needed to accept an input change (>=1).

Ports:
- clk, input, 1, system clock, all logic on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- left_in, input, 1, raw left-turn switch.
- right_in, input, 1, raw right-turn switch.
- hazard_in, input, 1, raw hazard switch.
- brake_in, input, 1, raw brake switch.
- lamps, output, 6, registered lamp pattern.
- mode, output, 2, current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ.
- step_tick, output, 1, one-cycle pulse on each prescaler wrap.

Behaviour:
- Reset (reset=0, asynchronous): lamps=000000, mode=IDLE, step=OFF, prescaler=0, step_tick=0, all synchronizers and debounced values 0.
- Input path: each raw input passes through a 2-flop synchronizer into a debouncer.
  - The debounced value flips on the edge where the synchronized value has differed from it for DEB_LEN consecutive cycles.
  - Any bounce restarts that count.
- Arbitration, evaluated every cycle from debounced values. Priority order:
  - hazard=1 or (left=1 and right=1) -> HAZ.
  - left only -> LEFT.
  - right only -> RIGHT.
  - none -> IDLE.
- Mode change: on the edge after the arbitrated mode differs from the mode register:
  - mode updates and the prescaler clears to 0.
  - step loads S1 for LEFT/RIGHT, ON for HAZ, OFF for IDLE.
  - No tick is issued on that edge.
- Prescaler: counts 0..TICK_DIV-1 while mode != IDLE. step_tick=1 for the cycle in which count==TICK_DIV-1, then count wraps to 0. In IDLE the prescaler is held at 0 and step_tick=0.
- Step advance (on a tick edge):
  - LEFT/RIGHT: S1 -> S2 -> S3 -> OFF -> S1, repeating.
  - HAZ: ON <-> OFF.
- Lamp decode: lamps is registered from the current mode/step/brake registers, so it lags state by exactly one cycle.
  - LEFT: S1 001000, S2 011000, S3 111000, OFF 000000.
  - RIGHT: S1 000001, S2 000011, S3 000111, OFF 000000.
  - HAZ: ON 111111, OFF 000000.
  - IDLE: 000000.
- Brake overlay (debounced brake=1):
  - IDLE: lamps=111111 steady.
  - LEFT: bits 2:0 forced to 111; bits 5:3 keep sweeping.
  - RIGHT: bits 5:3 forced to 111; bits 2:0 keep sweeping.
  - HAZ: brake ignored.
- Simultaneous events: a mode change and a tick on the same edge -> the mode change wins (step loads, prescaler clears). A brake change affects only the overlay and never restarts the sweep.
- Reset mid-sweep: all state returns to reset values immediately. After release, a still-held switch must re-pass the synchronizer plus DEB_LEN cycles before lamps light again.

Decomposition:
- Package tl_pkg:
  - mode encoding constants (IDLE, LEFT, RIGHT, HAZ).
  - step encoding constants (OFF, S1, S2, S3, ON).
  - lamp pattern constants (L1, L2, L3, R1, R2, R3, ALL, NONE).
- Sub-module tl_debounce: one instance per input; contains the 2-flop synchronizer plus DEB_LEN counter, parameterised by DEB_LEN, same clk/reset.

Test Plan:
- Reset held low with all inputs toggling -> lamps=000000, mode=0, step_tick=0 throughout. Release with inputs 0 -> outputs unchanged.
- left_in=1 held (TICK_DIV=4, DEB_LEN=3) -> mode=1, then lamps 001000. Thereafter lamps step 011000, 111000, 000000, 001000 every 4 cycles; step_tick period 4.
- left_in=1 with 1-cycle pulses shorter than DEB_LEN on right_in -> mode stays 1 and the sweep is uninterrupted.
- left_in=1 then right_in=1 mid-sweep -> mode=3, lamps 111111 then 000000 alternating every 4 cycles. Drop left_in -> mode=2, sweep restarts at 000001.
- brake_in=1 in IDLE -> lamps=111111. Brake held while right_in=1 -> lamps 111001, 111011, 111111, 111000 sequence. Brake with hazard_in=1 -> pure 111111/000000 alternation.
- reset pulsed low while lamps=011000 -> lamps=000000 on the same cycle. After release with left_in still 1 -> lamps return to 001000 only after the synchronizer plus DEB_LEN delay.
